hilo_muldiv_unit: RTL and testbench
===================================

HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/HI/LO width; even, >= 8.
REQ-002 SHALL have parameter MUL_LAT, default 2, multiply latency in cycles; legal range 1..4.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6-7 reserved.
REQ-008 SHALL have port src1  input  DATA_W  multiplicand / dividend / MTHI-MTLO data.
REQ-009 SHALL have port src2  input  DATA_W  multiplier / divisor.
REQ-010 SHALL have port cancel  input  1  flush/exception kill of the in-flight operation.
REQ-011 SHALL have port out_valid  output  1  result ready for commit.
REQ-012 SHALL have port out_ready  input  1  pipeline permits commit.
REQ-013 SHALL have ports res_hi, res_lo  output  DATA_W each  pending result; meaningful only while out_valid.
REQ-014 SHALL have ports hi, lo  output  DATA_W each  architectural HI/LO register values.

Function
REQ-015 SHALL use states IDLE, MUL, DIV, DONE; in_ready = (state==IDLE) && !cancel.
REQ-016 SHALL accept a request when in_valid && in_ready; acceptance cycle is T. Reserved op codes SHALL be accepted and ignored: no state change, no out_valid.
REQ-017 MULT/MULTU: SHALL go IDLE->MUL; out_valid at T+MUL_LAT; {res_hi,res_lo} = full 2*DATA_W product, signed (MULT) or unsigned (MULTU).
REQ-018 DIV/DIVU: SHALL go IDLE->DIV; use an iterative radix-2 restoring divider on magnitudes, one quotient bit per cycle; one sign-fix cycle follows; out_valid at T+DATA_W+1.
REQ-019 Division result SHALL be res_lo = quotient and res_hi = remainder. For DIV, quotient is negative iff operand signs differ. For DIV, remainder takes the sign of the dividend.
REQ-020 Divide by zero SHALL take normal latency: res_lo = all ones, res_hi = src1, for both DIV and DIVU.
REQ-021 DIV of most-negative by -1 SHALL give res_lo = most-negative and res_hi = 0.
REQ-022 MTHI/MTLO: SHALL go IDLE->DONE; out_valid at T+1; res_hi = src1 (MTHI) or res_lo = src1 (MTLO).
REQ-023 Operands SHALL be captured at T; later src1/src2 changes SHALL not affect the result.
REQ-024 In DONE, out_valid SHALL stay asserted, with res_hi/res_lo stable, until out_valid && out_ready.
REQ-025 On a DONE handshake without cancel: MULT*/DIV* SHALL write both hi and lo; MTHI SHALL write only hi; MTLO SHALL write only lo. New values are visible on hi/lo the following cycle; state returns to IDLE the same edge.
REQ-026 A new request SHALL not be accepted in the handshake cycle; earliest next acceptance is T_handshake+1.
REQ-027 cancel asserted in MUL, DIV or DONE SHALL force IDLE next edge, deassert out_valid, and leave hi/lo unchanged, including when cancel coincides with out_ready.
REQ-028 cancel with in_valid in IDLE SHALL cause no acceptance.
REQ-029 hi/lo SHALL change only per REQ-025.

Reset
REQ-030 reset SHALL immediately, without waiting for clk, force state=IDLE, out_valid=0, in_ready=1 (when cancel=0), hi=0, lo=0, res_hi=0, res_lo=0, divider/multiplier iteration state cleared.
REQ-031 reset mid-operation SHALL abandon the operation with no hi/lo write; the unit SHALL accept a new request on the first edge after reset deasserts.

Verification (DATA_W=32, MUL_LAT=2)
REQ-032 MULT src1=FFFFFFFD, src2=5, out_ready=1 -> out_valid at T+2, hi=FFFFFFFF, lo=FFFFFFF1 after commit; MULTU same operands -> hi=4, lo=FFFFFFF1.
REQ-033 DIV src1=FFFFFFF9 (-7), src2=2 -> out_valid at T+33, lo=FFFFFFFD, hi=FFFFFFFF; DIVU 7/0 -> lo=FFFFFFFF, hi=7; DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-034 DIVU 100/7 with out_ready=0 for 3 cycles after out_valid -> out_valid and res stable 3 cycles, in_ready=0; commit on 4th cycle -> lo=E, hi=2.
REQ-035 DIV launched at T, cancel at T+10 -> out_valid never asserts, in_ready=1 at T+11, hi/lo unchanged; cancel coinciding with handshake -> no write.
REQ-036 MTHI src1=12345678, then MTLO src1=9ABCDEF0 back-to-back -> each out_valid at T+1, hi=12345678, lo=9ABCDEF0, neither write disturbs the other register.
REQ-037 reset pulsed asynchronously mid-DIV (between edges) -> out_valid=0, hi=lo=0 immediately; new MULT after deassert completes per REQ-032.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply-divide unit: single-cycle-issue multiplier with fixed latency,
// iterative restoring divider, and MTHI/MTLO moves, committed by handshake.
module hilo_muldiv_unit #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              cancel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [1:0]          state;
  logic [2:0]          op_q;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   dvs_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   quo_q;

  logic                accept;
  logic                commit;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [2*DATA_W-1:0] first_step;
  logic [2*DATA_W-1:0] next_step;
  logic [DATA_W-1:0]   fix_hi;
  logic [DATA_W-1:0]   fix_lo;

  function automatic logic [2*DATA_W-1:0] mul_full(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y,
                                                   input logic              sgn);
    logic signed [2*DATA_W-1:0] xs;
    logic signed [2*DATA_W-1:0] ys;
    xs = sgn ? {{DATA_W{x[DATA_W-1]}}, x} : {{DATA_W{1'b0}}, x};
    ys = sgn ? {{DATA_W{y[DATA_W-1]}}, y} : {{DATA_W{1'b0}}, y};
    return xs * ys;
  endfunction

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic sgn);
    return (sgn && x[DATA_W-1]) ? (~x + DATA_W'(1)) : x;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] x, input logic neg);
    return neg ? (~x + DATA_W'(1)) : x;
  endfunction

  // One restoring step: dividend bits shift out of quo's MSB while quotient bits enter at its LSB.
  function automatic logic [2*DATA_W-1:0] div_step(input logic [DATA_W-1:0] rem,
                                                   input logic [DATA_W-1:0] quo,
                                                   input logic [DATA_W-1:0] dvs);
    logic [DATA_W:0] trial;
    trial = {rem, quo[DATA_W-1]};
    if (trial >= {1'b0, dvs}) begin
      trial = trial - {1'b0, dvs};
      return {trial[DATA_W-1:0], quo[DATA_W-2:0], 1'b1};
    end
    return {trial[DATA_W-1:0], quo[DATA_W-2:0], 1'b0};
  endfunction

  assign in_ready  = (state == IDLE) && !cancel;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign commit    = out_valid && out_ready && !cancel;

  // Shared multiplier: fed straight from the ports only when MUL_LAT is 1.
  assign prod = (state == IDLE) ? mul_full(src1, src2, op == OP_MULT)
                                : mul_full(a_q, b_q, op_q == OP_MULT);

  assign mag_a      = mag(src1, op == OP_DIV);
  assign mag_b      = mag(src2, op == OP_DIV);
  assign first_step = div_step('0, mag_a, mag_b);
  assign next_step  = div_step(rem_q, quo_q, dvs_q);

  // Divide by zero reports all-ones quotient and the raw dividend as remainder.
  assign fix_lo = (b_q == '0) ? '1
                : apply_sign(quo_q, (op_q == OP_DIV) && (a_q[DATA_W-1] ^ b_q[DATA_W-1]));
  assign fix_hi = (b_q == '0) ? a_q
                : apply_sign(rem_q, (op_q == OP_DIV) && a_q[DATA_W-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= '0;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      res_hi <= '0;
      res_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= op;
            a_q  <= src1;
            b_q  <= src2;
            case (op)
              OP_MULT, OP_MULTU: begin
                if (MUL_LAT <= 1) begin
                  res_hi <= prod[2*DATA_W-1:DATA_W];
                  res_lo <= prod[DATA_W-1:0];
                  state  <= DONE;
                end else begin
                  cnt   <= CNT_W'(MUL_LAT - 1);
                  state <= MUL;
                end
              end
              OP_DIV, OP_DIVU: begin
                dvs_q          <= mag_b;
                {rem_q, quo_q} <= first_step;
                cnt            <= CNT_W'(DATA_W - 1);
                state          <= DIV;
              end
              OP_MTHI: begin
                res_hi <= src1;
                state  <= DONE;
              end
              OP_MTLO: begin
                res_lo <= src1;
                state  <= DONE;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          if (cancel) begin
            state <= IDLE;
          end else if (cnt <= CNT_W'(1)) begin
            res_hi <= prod[2*DATA_W-1:DATA_W];
            res_lo <= prod[DATA_W-1:0];
            state  <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DIV: begin
          if (cancel) begin
            state <= IDLE;
          end else if (cnt != '0) begin
            {rem_q, quo_q} <= next_step;
            cnt            <= cnt - CNT_W'(1);
          end else begin
            res_hi <= fix_hi;
            res_lo <= fix_lo;
            state  <= DONE;
          end
        end
        DONE: begin
          if (cancel) begin
            state <= IDLE;
          end else if (commit) begin
            if (op_q != OP_MTLO) hi <= res_hi;
            if (op_q != OP_MTHI) lo <= res_lo;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: directed vectors with hand-computed results.
module tb_hilo_muldiv_unit;
  localparam int W       = 32;
  localparam int MUL_LAT = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         cancel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res_hi;
  logic [W-1:0] res_lo;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct {
    logic [W-1:0] rhi;
    logic [W-1:0] rlo;
    bit           chk_h;
    bit           chk_l;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  hilo_muldiv_unit #(.DATA_W(W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .cancel(cancel),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_hi(res_hi), .res_lo(res_lo), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every committed result is popped and compared.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && !cancel) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: out_valid with empty scoreboard, res_hi=%h res_lo=%h",
                 res_hi, res_lo);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk_h) check("res_hi", 64'(res_hi), 64'(mon_e.rhi));
        if (mon_e.chk_l) check("res_lo", 64'(res_lo), 64'(mon_e.rlo));
      end
    end
  end

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] rhi, input logic [W-1:0] rlo,
                        input bit chk_h, input bit chk_l,
                        input int exp_lat, input int stall, input string name);
    int           lat;
    logic [W-1:0] hold_hi;
    logic [W-1:0] hold_lo;
    exp_t         e;
    @(posedge clk); #1;
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    op        = o;
    src1      = a;
    src2      = b;
    e.rhi = rhi; e.rlo = rlo; e.chk_h = chk_h; e.chk_l = chk_l;
    sb.push_back(e);
    @(negedge clk);
    check({name, "_in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    src1     = $urandom;
    src2     = $urandom;
    wait_valid(lat);
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    if (out_valid) begin
      hold_hi = res_hi;
      hold_lo = res_lo;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        if (s == stall - 1) out_ready = 1'b1;
        @(negedge clk);
        check({name, "_stall_valid"}, 64'(out_valid), 64'(1));
        check({name, "_stall_res"}, {res_hi, res_lo}, {hold_hi, hold_lo});
        check({name, "_stall_in_ready"}, 64'(in_ready), 64'(0));
      end
      @(posedge clk);
      @(negedge clk);
      if (chk_h) model_hi = rhi;
      if (chk_l) model_lo = rlo;
      check({name, "_hi"}, 64'(hi), 64'(model_hi));
      check({name, "_lo"}, 64'(lo), 64'(model_lo));
      check({name, "_idle"}, 64'({out_valid, in_ready}), 64'(2'b01));
    end
  endtask

  initial begin
    int  lat;
    bit  seen;
    reset = 1'b0; in_valid = 1'b0; cancel = 1'b0; out_ready = 1'b1;
    op = '0; src1 = '0; src2 = '0;
    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_hilo", {hi, lo}, 64'(0));
    check("rst_res", {res_hi, res_lo}, 64'(0));
    #10 reset = 1'b0;

    run_op(3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1, 1, MUL_LAT, 0, "mult");
    run_op(3'd1, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1, 1, 1, MUL_LAT, 0, "multu");
    run_op(3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1, 1, MUL_LAT, 0, "mult_min");
    run_op(3'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1, 1, MUL_LAT, 0, "mult_neg1");
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1, 1, W + 1, 0, "div_neg");
    run_op(3'd2, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1, 1, W + 1, 0, "div_negdvs");
    run_op(3'd3, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF, 1, 1, W + 1, 0, "divu_zero");
    run_op(3'd2, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1, 1, W + 1, 0, "div_zero");
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1, 1, W + 1, 0, "div_ovf");
    run_op(3'd3, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1, 1, W + 1, 3, "divu_stall");

    // Reserved op code: accepted, but nothing happens.
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; op = 3'd6; src1 = 32'h11111111; src2 = 32'h2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen = 1'b1;
    end
    check("reserved_quiet", 64'(seen), 64'(0));
    check("reserved_hilo", {hi, lo}, {model_hi, model_lo});

    // Cancel together with a request in IDLE: not accepted.
    @(posedge clk); #1;
    in_valid = 1'b1; op = 3'd4; src1 = 32'hDEADBEEF; cancel = 1'b1;
    @(negedge clk);
    check("cancel_idle_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    in_valid = 1'b0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("cancel_idle_no_out", 64'(out_valid), 64'(0));
    check("cancel_idle_hi", 64'(hi), 64'(model_hi));

    // DIV cancelled in cycle T+10.
    @(posedge clk); #1;
    in_valid = 1'b1; op = 3'd2; src1 = 32'd1000; src2 = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(negedge clk);
    check("cancel_div_in_ready_low", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    check("cancel_div_in_ready", 64'(in_ready), 64'(1));
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("cancel_div_no_out", 64'(seen), 64'(0));
    check("cancel_div_hilo", {hi, lo}, {model_hi, model_lo});

    // Cancel coinciding with the commit handshake: no write.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd0; src1 = 32'd3; src2 = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("cancel_hs_latency", 64'(lat), 64'(MUL_LAT));
    @(posedge clk); #1;
    out_ready = 1'b1; cancel = 1'b1;
    @(negedge clk);
    check("cancel_hs_valid", 64'(out_valid), 64'(1));
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    check("cancel_hs_out_valid", 64'(out_valid), 64'(0));
    check("cancel_hs_hilo", {hi, lo}, {model_hi, model_lo});

    run_op(3'd4, 32'h12345678, 32'h0, 32'h12345678, 32'h0, 1, 0, 1, 0, "mthi");
    run_op(3'd5, 32'h9ABCDEF0, 32'h0, 32'h0, 32'h9ABCDEF0, 0, 1, 1, 0, "mtlo");

    // Asynchronous reset in the middle of a DIV.
    @(posedge clk); #1;
    in_valid = 1'b1; op = 3'd2; src1 = 32'd100; src2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("amid_rst_out_valid", 64'(out_valid), 64'(0));
    check("amid_rst_hilo", {hi, lo}, 64'(0));
    check("amid_rst_in_ready", 64'(in_ready), 64'(1));
    #2 reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("amid_rst_abandoned", 64'(seen), 64'(0));
    run_op(3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1, 1, MUL_LAT, 0, "mult_post_rst");

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d vectors applied", n_vec);
    $fatal(1, "timeout");
  end

endmodule
